// File: rtl/gan_pkg.sv
// Shared fixed-point types, FSM encoding and the Q8.8 shift/saturate helper for the generator layers.
package gan_pkg;

    localparam int Q_FRAC = 8;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;

    typedef logic signed [DATA_W-1:0] q8_8_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WRITE,
        S_DONE
    } l1_state_t;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32'sd32768);

    // Arithmetic shift floors toward -inf; result clamps to the Q8.8 range.
    function automatic q8_8_t sat_q8_8(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] s;
        s = acc >>> Q_FRAC;
        if (s > SAT_HI)
            return q8_8_t'(16'h7FFF);
        else if (s < SAT_LO)
            return q8_8_t'(16'h8000);
        else
            return q8_8_t'(s[DATA_W-1:0]);
    endfunction

endpackage

// File: rtl/layer1_weight_rom.sv
// Synchronous ROM for layer weights or biases, contents from a constant fill or a seeded address hash.
// Latency: one cycle from i_addr to o_dat.
// Backpressure: none, a read is issued every cycle.
module layer1_weight_rom #(
    parameter int                DEPTH     = 256,
    parameter int                WIDTH     = 16,
    parameter string             INIT_FILE = "",
    parameter logic [WIDTH-1:0]  FILL      = '0,
    parameter logic [31:0]       SEED      = '0
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    output logic [WIDTH-1:0]         o_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    initial begin
        logic [31:0] h;
        for (int a = 0; a < DEPTH; a++) begin
            h        = 32'(a) * 32'd2654435761 + SEED;
            r_mem[a] = (SEED == '0) ? FILL : h[8 +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        o_dat <= r_mem[i_addr];
    end

endmodule

// File: rtl/layer1_generator.sv
// Generator FC layer 1: y[j] = sat(sum_i W[j][i]*x[i] + b[j]) via one time-shared MAC.
// Latency 16641 cycles from accepted start to done; start ignored while busy, no other backpressure.
module layer1_generator
    import gan_pkg::*;
#(
    parameter int                 N_IN        = 64,
    parameter int                 N_OUT       = 256,
    parameter string              WEIGHT_FILE = "layer1_gen_weights.hex",
    parameter string              BIAS_FILE   = "layer1_gen_bias.hex",
    parameter logic [DATA_W-1:0]  W_FILL      = '0,
    parameter logic [DATA_W-1:0]  B_FILL      = '0,
    parameter logic [31:0]        W_SEED      = '0,
    parameter logic [31:0]        B_SEED      = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W*N_IN-1:0]  flat_input_flat,
    output logic [DATA_W*N_OUT-1:0] flat_output_flat,
    output logic                    done
);

    localparam int I_W  = $clog2(N_IN);
    localparam int J_W  = $clog2(N_OUT);
    localparam int WA_W = $clog2(N_IN * N_OUT);

    l1_state_t                r_state, w_state_nxt;
    logic                     w_accept;
    logic [I_W-1:0]           r_i, r_i_d;
    logic [J_W-1:0]           r_j, r_wr_j;
    logic                     r_mac_d, r_wr_d, r_done;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W*N_IN-1:0]   r_x;
    logic [DATA_W*N_OUT-1:0]  r_y;

    logic                     w_last_i, w_last_j;
    logic [WA_W-1:0]          w_waddr;
    q8_8_t                    w_wdat, w_bdat, w_xsel, w_res;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext, w_bias_ext;

    assign w_last_i = (r_i == I_W'(N_IN - 1));
    assign w_last_j = (r_j == J_W'(N_OUT - 1));
    assign w_waddr  = WA_W'(r_j) * WA_W'(N_IN) + WA_W'(r_i);

    layer1_weight_rom #(
        .DEPTH(N_IN * N_OUT), .WIDTH(DATA_W), .INIT_FILE(WEIGHT_FILE), .FILL(W_FILL), .SEED(W_SEED)
    ) u_wrom (
        .clk(clk), .i_addr(w_waddr), .o_dat(w_wdat)
    );

    layer1_weight_rom #(
        .DEPTH(N_OUT), .WIDTH(DATA_W), .INIT_FILE(BIAS_FILE), .FILL(B_FILL), .SEED(B_SEED)
    ) u_brom (
        .clk(clk), .i_addr(r_j), .o_dat(w_bdat)
    );

    // ROM data trails the address by a cycle, so the MAC uses the delayed index and the
    // final write lands one cycle after the WRITE state.
    assign w_xsel     = q8_8_t'(r_x[r_i_d*DATA_W +: DATA_W]);
    assign w_prod     = w_wdat * w_xsel;
    assign w_prod_ext = $signed({{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod});
    assign w_bias_ext = $signed({{(ACC_W-DATA_W-Q_FRAC){w_bdat[DATA_W-1]}}, w_bdat, {Q_FRAC{1'b0}}});
    assign w_res      = sat_q8_8(r_acc + w_bias_ext);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC:   if (w_last_i) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last_j ? S_DONE : S_MAC;
            S_DONE: begin
                if (start && r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_i_d   <= '0;
            r_j     <= '0;
            r_wr_j  <= '0;
            r_mac_d <= 1'b0;
            r_wr_d  <= 1'b0;
            r_done  <= 1'b0;
            r_acc   <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mac_d <= (r_state == S_MAC);
            r_wr_d  <= (r_state == S_WRITE);
            r_i_d   <= r_i;
            r_wr_j  <= r_j;

            if (w_accept) begin
                r_x <= flat_input_flat;
                r_i <= '0;
                r_j <= '0;
            end else if (r_state == S_MAC) begin
                r_i <= w_last_i ? '0 : r_i + 1'b1;
            end else if (r_state == S_WRITE && !w_last_j) begin
                r_j <= r_j + 1'b1;
            end

            if (w_accept || r_wr_d)
                r_acc <= '0;
            else if (r_mac_d)
                r_acc <= r_acc + w_prod_ext;

            if (r_wr_d)
                r_y[r_wr_j*DATA_W +: DATA_W] <= w_res;

            if (w_accept)
                r_done <= 1'b0;
            else if (r_wr_d && r_wr_j == J_W'(N_OUT - 1))
                r_done <= 1'b1;
        end
    end

    assign flat_output_flat = r_y;
    assign done             = r_done;

endmodule

// File: tb/tb_layer1_generator.sv
// Bench for layer1_generator: a hashed-ROM instance and an all-0x7FFF-weight instance checked
// every cycle against a pass-level model, plus hand-computed literals for latency and selected neurons.
module tb_layer1_generator;

    localparam int          NI  = 64;
    localparam int          NO  = 256;
    localparam int          LAT = NO * (NI + 1) + 1;
    localparam logic [31:0] WS  = 32'h0000_1234;
    localparam logic [31:0] BS  = 32'h0000_9876;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              st0 = 1'b0, st1 = 1'b0;
    logic [16*NI-1:0]  x0 = '0, x1 = '0;
    logic [16*NO-1:0]  y0, y1;
    logic              done0, done1;

    int n_tot = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    layer1_generator #(
        .WEIGHT_FILE(""), .BIAS_FILE(""), .W_SEED(WS), .B_SEED(BS)
    ) u_dut (
        .clk(clk), .rst(rst), .start(st0), .flat_input_flat(x0), .flat_output_flat(y0), .done(done0)
    );

    layer1_generator #(
        .WEIGHT_FILE(""), .BIAS_FILE(""), .W_FILL(16'h7FFF), .B_FILL(16'h0000)
    ) u_sat (
        .clk(clk), .rst(rst), .start(st1), .flat_input_flat(x1), .flat_output_flat(y1), .done(done1)
    );

    // ---------------- model ----------------
    function automatic int s16(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    function automatic int hashv(input int a, input logic [31:0] seed);
        longint unsigned v;
        v = (longint'(a) * 64'd2654435761 + 64'(seed)) % 64'h1_0000_0000;
        return s16(int'((v / 256) % 65536));
    endfunction

    function automatic int rom_w(input int d, input int j, input int i);
        return (d == 0) ? hashv(j * NI + i, WS) : 32767;
    endfunction

    function automatic int rom_b(input int d, input int j);
        return (d == 0) ? hashv(j, BS) : 0;
    endfunction

    function automatic logic [16*NO-1:0] golden(input int d, input logic [16*NI-1:0] xv);
        logic [16*NO-1:0] out;
        longint sum, q;
        logic [15:0] xw;
        out = '0;
        for (int j = 0; j < NO; j++) begin
            sum = 0;
            for (int i = 0; i < NI; i++) begin
                xw  = xv[16*i +: 16];
                sum += longint'(rom_w(d, j, i)) * longint'(s16(int'(xw)));
            end
            q = sum / 256;
            if (sum < 0 && q * 256 != sum) q = q - 1;
            q = q + longint'(rom_b(d, j));
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
            out[16*j +: 16] = 16'(q);
        end
        return out;
    endfunction

    bit               m_busy [2];
    bit               m_done [2];
    int               m_cnt  [2];
    logic [16*NO-1:0] m_y    [2];
    logic [16*NO-1:0] m_pend [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic             s;
            logic [16*NI-1:0] xv;
            s  = (d == 0) ? st0 : st1;
            xv = (d == 0) ? x0 : x1;
            if (!rst) begin
                m_busy[d] = 1'b0;
                m_done[d] = 1'b0;
                m_cnt[d]  = 0;
                m_y[d]    = '0;
            end else if (s && !m_busy[d]) begin
                m_pend[d] = golden(d, xv);
                m_busy[d] = 1'b1;
                m_done[d] = 1'b0;
                m_cnt[d]  = LAT;
            end else if (m_busy[d]) begin
                m_cnt[d] = m_cnt[d] - 1;
                if (m_cnt[d] == 0) begin
                    m_busy[d] = 1'b0;
                    m_done[d] = 1'b1;
                    m_y[d]    = m_pend[d];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                logic             dv;
                logic [16*NO-1:0] yv;
                int               bad_j;
                dv = (d == 0) ? done0 : done1;
                yv = (d == 0) ? y0 : y1;
                n_tot++;
                if (dv !== m_done[d]) begin
                    n_bad++;
                    $display("FAIL done[%0d] t=%0t got %b expected %b", d, $time, dv, m_done[d]);
                end
                if (!m_busy[d]) begin
                    n_tot++;
                    if (yv !== m_y[d]) begin
                        n_bad++;
                        bad_j = -1;
                        for (int j = NO - 1; j >= 0; j--)
                            if (yv[16*j +: 16] !== m_y[d][16*j +: 16]) bad_j = j;
                        if (bad_j >= 0)
                            $display("FAIL y[%0d] t=%0t neuron %0d got %h expected %h", d, $time, bad_j,
                                     yv[16*bad_j +: 16], m_y[d][16*bad_j +: 16]);
                        else
                            $display("FAIL y[%0d] t=%0t unknown bits in output vector", d, $time);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse(input bit s0, input bit s1);
        st0 = s0;
        st1 = s1;
        @(posedge clk);
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    // Counts edges after the start edge until each done is seen; -1 means it never rose.
    task automatic run_wait(input bit stab, output int l0, output int l1);
        int cnt;
        cnt = 0;
        l0  = -1;
        l1  = -1;
        while ((l0 < 0 || l1 < 0) && cnt < LAT + 100) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (stab && cnt == 10)
                for (int i = 0; i < NI; i++) x0[16*i +: 16] = 16'($urandom_range(0, 65535));
            if (stab && cnt == 20) st0 = 1'b1;
            if (stab && cnt == 21) st0 = 1'b0;
            if (done0 && l0 < 0) l0 = cnt;
            if (done1 && l1 < 0) l1 = cnt;
        end
    endtask

    initial begin
        int l0, l1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_done0", 32'(done0), 32'd0);
        chk("reset_y0_zero", 32'(y0 == '0), 32'd1);
        chk("reset_y1_zero", 32'(y1 == '0), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Pass 1: zero input on the hashed instance, +0x7FFF input on the saturating one.
        x0 = '0;
        x1 = {NI{16'h7FFF}};
        pulse(1'b1, 1'b1);
        run_wait(1'b0, l0, l1);
        chk("p1_latency0", 32'(l0), 32'(LAT));
        chk("p1_latency1", 32'(l1), 32'(LAT));
        chk("p1_y0_n0_bias", 32'(y0[0 +: 16]), 32'h0098);
        chk("p1_y0_n3_negbias", 32'(y0[48 +: 16]), 32'hA705);
        chk("p1_sat_pos", 32'(y1 == {NO{16'h7FFF}}), 32'd1);

        // Pass 2 back-to-back: unit input, input disturbed and a stray start mid-pass.
        x0 = '0;
        x0[15:0] = 16'h0100;
        x1 = {NI{16'h8001}};
        pulse(1'b1, 1'b1);
        chk("p2_done0_drop", 32'(done0), 32'd0);
        chk("p2_done1_drop", 32'(done1), 32'd0);
        run_wait(1'b1, l0, l1);
        chk("p2_latency0", 32'(l0), 32'(LAT));
        chk("p2_latency1", 32'(l1), 32'(LAT));
        chk("p2_y0_n0_unit", 32'(y0[0 +: 16]), 32'h00AA);
        chk("p2_y0_n3_sat", 32'(y0[48 +: 16]), 32'h8000);
        chk("p2_sat_neg", 32'(y1 == {NO{16'h8000}}), 32'd1);

        // Pass 3: full-range input, aborted by reset on edge 5000 of the pass.
        for (int i = 0; i < NI; i++) x0[16*i +: 16] = 16'($urandom_range(0, 65535));
        pulse(1'b1, 1'b0);
        repeat (4998) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_done0", 32'(done0), 32'd0);
        chk("abort_y0_zero", 32'(y0 == '0), 32'd1);
        chk("abort_y1_zero", 32'(y1 == '0), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Pass 4: small signed input for mostly unsaturated sums; zero input on the other instance.
        for (int i = 0; i < NI; i++) x0[16*i +: 16] = 16'(int'($urandom_range(0, 128)) - 64);
        x1 = '0;
        pulse(1'b1, 1'b1);
        run_wait(1'b0, l0, l1);
        chk("p4_latency0", 32'(l0), 32'(LAT));
        chk("p4_latency1", 32'(l1), 32'(LAT));
        chk("p4_y1_zero", 32'(y1 == '0), 32'd1);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
